// File: rtl/boolfuck_pkg.sv
// rtl/boolfuck_pkg.sv - shared types and constants for the boolfuck run controller
//
// Purpose: controller FSM state type, the 3-bit opcode constants shared with
// the interpreter core, and the host byte width.
// Ports: none (package).
// Configuration macro: BOOLFUCK_WDOG_EN (used by boolfuck_ctrl).
package boolfuck_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FLUSH = 2'd3
  } ctrl_state_t;

  // Opcode encoding of the core's program memory.
  localparam logic [2:0] OP_FLIP  = 3'd0;  // +
  localparam logic [2:0] OP_IN    = 3'd1;  // ,
  localparam logic [2:0] OP_OUT   = 3'd2;  // ;
  localparam logic [2:0] OP_LEFT  = 3'd3;  // <
  localparam logic [2:0] OP_RIGHT = 3'd4;  // >
  localparam logic [2:0] OP_LOOP  = 3'd5;  // [
  localparam logic [2:0] OP_END   = 3'd6;  // ]
  localparam logic [2:0] OP_HALT  = 3'd7;  // end of program

endpackage

// File: rtl/boolfuck_pack.sv
// rtl/boolfuck_pack.sv - output bit packer with holding register and flush
//
// Purpose: shifts retired output bits in LSB-first, moves each complete byte
// into a holding register presented on a valid/ready port, and on flush pads
// a partial byte with zeros.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clear           discard the partial byte (start / abort)
//   i_bit_vld, i_bit  a retired output bit
//   i_flush           push a partial byte if any bits are held
//   i_out_rdy         host ready
//   o_out_byte/o_out_vld  host byte and valid
//   o_blocked         the next bit would complete a byte that cannot be stored
//   o_empty           no partial bits held
//   o_flush_ok        holding register can take a byte this cycle
module boolfuck_pack
  import boolfuck_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_bit_vld,
  input  logic              i_bit,
  input  logic              i_flush,
  input  logic              i_out_rdy,
  output logic [BYTE_W-1:0] o_out_byte,
  output logic              o_out_vld,
  output logic              o_blocked,
  output logic              o_empty,
  output logic              o_flush_ok
);

  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] r_hold;
  logic [2:0]        r_cnt;
  logic              r_vld;

  logic              w_hold_free;
  logic              w_bit_acc;
  logic              w_load_full;
  logic              w_load_flush;
  logic              w_load;
  logic [BYTE_W-1:0] w_next_shift;
  logic [BYTE_W-1:0] w_mask;

  // The holding register is free when empty or being read this cycle,
  // which lets a new byte load in the same cycle as a handshake.
  assign w_hold_free  = ~r_vld | i_out_rdy;
  assign o_blocked    = (r_cnt == 3'd7) & ~w_hold_free;
  assign o_empty      = (r_cnt == 3'd0);
  assign o_flush_ok   = w_hold_free;

  assign w_bit_acc    = i_bit_vld & ~o_blocked & ~i_clear;
  assign w_load_full  = w_bit_acc & (r_cnt == 3'd7);
  assign w_load_flush = i_flush & ~o_empty & w_hold_free & ~i_clear;
  assign w_load       = w_load_full | w_load_flush;

  // Bits above the count are stale leftovers of the previous byte.
  assign w_mask       = (BYTE_W'(1) << r_cnt) - BYTE_W'(1);

  always_comb begin
    w_next_shift        = r_shift;
    w_next_shift[r_cnt] = i_bit;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_hold  <= '0;
      r_cnt   <= 3'd0;
      r_vld   <= 1'b0;
    end else begin
      if (i_clear) begin
        r_shift <= '0;
        r_cnt   <= 3'd0;
      end else if (w_load_flush) begin
        r_cnt   <= 3'd0;
      end else if (w_bit_acc) begin
        r_shift <= w_next_shift;
        r_cnt   <= r_cnt + 3'd1;
      end

      if (w_load_full) begin
        r_hold <= w_next_shift;
      end else if (w_load_flush) begin
        r_hold <= r_shift & w_mask;
      end

      if (w_load) begin
        r_vld <= 1'b1;
      end else if (i_out_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_out_byte = r_hold;
  assign o_out_vld  = r_vld;

endmodule

// File: rtl/boolfuck_ctrl.sv
// rtl/boolfuck_ctrl.sv - run controller and bit-I/O scheduler for the boolfuck core
//
// Purpose: sequences the core through start, run, breakpoint pause,
// single-step, flush and abort; packs output bits into host bytes and
// unpacks host bytes into input bits, stalling the core when I/O blocks.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_go, i_stp, i_abt            start/resume, single-step, abort buttons (levels)
//   i_brk_en, i_brk_pc            breakpoint enable and address
//   i_core_pc                     core's current instruction address
//   i_core_halt/out/in, i_core_obit  current instruction decode and output bit
//   o_core_run, o_core_start      execute enable, core clear pulse
//   o_core_ibit                   bit for the current input instruction
//   o_out_byte/o_out_vld/i_out_rdy   host output byte stream
//   i_in_byte/i_in_vld/o_in_rdy      host input byte stream
//   o_state, o_stall, o_wdog_trip status
// Configuration macro: BOOLFUCK_WDOG_EN enables the W-bit retire watchdog.
module boolfuck_ctrl
  import boolfuck_pkg::*;
#(
  parameter int C = 8,
  parameter int W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  input  logic              i_stp,
  input  logic              i_abt,
  input  logic              i_brk_en,
  input  logic [C-1:0]      i_brk_pc,
  input  logic [C-1:0]      i_core_pc,
  input  logic              i_core_halt,
  input  logic              i_core_out,
  input  logic              i_core_in,
  input  logic              i_core_obit,
  output logic              o_core_run,
  output logic              o_core_start,
  output logic              o_core_ibit,
  output logic [BYTE_W-1:0] o_out_byte,
  output logic              o_out_vld,
  input  logic              i_out_rdy,
  input  logic [BYTE_W-1:0] i_in_byte,
  input  logic              i_in_vld,
  output logic              o_in_rdy,
  output logic [1:0]        o_state,
  output logic              o_stall,
  output logic              o_wdog_trip
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic              r_go_q;
  logic              r_stp_q;
  logic              r_abt_q;
  logic              r_bp_mask;
  logic [BYTE_W-1:0] r_ibuf;
  logic [2:0]        r_icnt;
  logic              r_ifull;

  logic w_go_edge, w_stp_edge, w_abt_edge;
  logic w_run, w_start, w_flush, w_pk_clear, w_set_mask;
  logic w_active, w_stall, w_bp_hit, w_wdog_hit;
  logic w_pk_blocked, w_pk_empty, w_pk_flush_ok;
  logic w_in_acc, w_in_take;

  assign w_go_edge  = i_go  & ~r_go_q;
  assign w_stp_edge = i_stp & ~r_stp_q;
  assign w_abt_edge = i_abt & ~r_abt_q;

  assign w_active = (r_state == ST_RUN) | (r_state == ST_PAUSE);
  assign w_stall  = w_active & ((i_core_out & w_pk_blocked) | (i_core_in & ~r_ifull));
  assign w_bp_hit = i_brk_en & (i_core_pc == i_brk_pc) & ~r_bp_mask;

  always_comb begin
    w_next_state = r_state;
    w_run        = 1'b0;
    w_start      = 1'b0;
    w_flush      = 1'b0;
    w_pk_clear   = 1'b0;
    w_set_mask   = 1'b0;
    if (w_abt_edge) begin
      w_next_state = ST_IDLE;
      w_pk_clear   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go_edge) begin
            w_start      = 1'b1;
            w_pk_clear   = 1'b1;
            w_next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_wdog_hit) begin
            w_next_state = ST_IDLE;
          end else if (w_bp_hit) begin
            w_next_state = ST_PAUSE;
          end else begin
            w_run = ~w_stall;
            if (w_run && i_core_halt) w_next_state = ST_FLUSH;
          end
        end
        ST_PAUSE: begin
          if (w_wdog_hit) begin
            w_next_state = ST_IDLE;
          end else if (w_go_edge) begin
            w_next_state = ST_RUN;
            w_set_mask   = 1'b1;
          end else if (w_stp_edge) begin
            // A step ignores the breakpoint: it is how the paused
            // instruction gets executed.
            w_run = ~w_stall;
            if (w_run && i_core_halt) w_next_state = ST_FLUSH;
          end
        end
        default: begin
          w_flush = 1'b1;
          if (w_pk_empty || w_pk_flush_ok) w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_go_q    <= 1'b0;
      r_stp_q   <= 1'b0;
      r_abt_q   <= 1'b0;
      r_bp_mask <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_go_q  <= i_go;
      r_stp_q <= i_stp;
      r_abt_q <= i_abt;
      // Mask holds only until the resumed instruction retires.
      if (w_set_mask) begin
        r_bp_mask <= 1'b1;
      end else if (w_run || w_start || w_abt_edge) begin
        r_bp_mask <= 1'b0;
      end
    end
  end

  // Input unpacker: one byte buffer consumed LSB first.
  assign w_in_acc  = i_in_vld & ~r_ifull;
  assign w_in_take = w_run & i_core_in;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ibuf  <= '0;
      r_icnt  <= 3'd0;
      r_ifull <= 1'b0;
    end else if (w_in_acc) begin
      // Accept wins over a start clear: the unpacker was empty anyway,
      // so a byte offered in the start cycle is kept rather than dropped.
      r_ibuf  <= i_in_byte;
      r_icnt  <= 3'd0;
      r_ifull <= 1'b1;
    end else if (w_start) begin
      r_icnt  <= 3'd0;
      r_ifull <= 1'b0;
    end else if (w_in_take) begin
      r_icnt <= r_icnt + 3'd1;
      if (r_icnt == 3'd7) r_ifull <= 1'b0;
    end
  end

`ifdef BOOLFUCK_WDOG_EN
  logic [W-1:0] r_wdog_cnt;
  logic         r_wdog_trip;

  assign w_wdog_hit = &r_wdog_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wdog_cnt  <= '0;
      r_wdog_trip <= 1'b0;
    end else if (w_start) begin
      r_wdog_cnt  <= '0;
      r_wdog_trip <= 1'b0;
    end else begin
      if (w_run) r_wdog_cnt <= r_wdog_cnt + W'(1);
      if (w_wdog_hit && w_active && !w_abt_edge) r_wdog_trip <= 1'b1;
    end
  end

  assign o_wdog_trip = r_wdog_trip;
`else
  assign w_wdog_hit  = 1'b0;
  assign o_wdog_trip = 1'b0;
`endif

  boolfuck_pack u_pack (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_pk_clear),
    .i_bit_vld  (w_run & i_core_out),
    .i_bit      (i_core_obit),
    .i_flush    (w_flush),
    .i_out_rdy  (i_out_rdy),
    .o_out_byte (o_out_byte),
    .o_out_vld  (o_out_vld),
    .o_blocked  (w_pk_blocked),
    .o_empty    (w_pk_empty),
    .o_flush_ok (w_pk_flush_ok)
  );

  assign o_core_run   = w_run;
  assign o_core_start = w_start;
  assign o_core_ibit  = r_ibuf[r_icnt];
  assign o_in_rdy     = ~r_ifull;
  assign o_state      = r_state;
  assign o_stall      = w_stall;

endmodule

// File: doc/boolfuck_ctrl.md
# boolfuck_ctrl

Run controller and bit-I/O scheduler for the boolfuck interpreter core. Sequences the core through start, free-run, breakpoint pause, single-step and abort. Packs the core's output bits into host bytes and unpacks host bytes into input bits, stalling the core whenever I/O cannot be serviced. Sits between the board buttons or host byte stream and the core's execute-enable.

## Interface
- `C`, default 8: program-counter width; matches the core's program address width.
- `W`, default 16: watchdog instruction-counter width.
- `clk` in 1: the single clock; everything is `posedge clk`.
- `rst` in 1: asynchronous, active-high reset.
- `go`, `stp`, `abt` in 1 each: level buttons for start/resume, single-step and abort. Rising edges are detected internally against registered copies.
- `brk_en` in 1, `brk_pc` in C: breakpoint enable and breakpoint address.
- `core_pc` in C: the core's current instruction address.
- `core_halt`, `core_out`, `core_in` in 1 each: levels flagging that the current instruction is halt, output-bit or input-bit.
- `core_obit` in 1: the bit the current output instruction emits.
- `core_run` out 1: execute enable. The current instruction retires on each cycle this is high.
- `core_start` out 1: one-cycle pulse that clears the core's pointer, stack and pc.
- `core_ibit` out 1: bit supplied to the current input instruction.
- `out_byte` out 8, `out_vld` out 1, `out_rdy` in 1: host output byte, valid/ready handshake.
- `in_byte` in 8, `in_vld` in 1, `in_rdy` out 1: host input byte, valid/ready handshake.
- `state` out 2: current FSM state.
- `stall` out 1: I/O is blocking the core this cycle.
- `wdog_trip` out 1: sticky watchdog flag.

## Operation
- FSM states and transitions:
  - IDLE: `go` edge pulses `core_start`, clears the watchdog, the packer and the unpacker, and moves to RUN.
  - RUN: `core_run` = ~`stall` & ~`bp_hit`.
    - `bp_hit` = `brk_en` & (`core_pc`==`brk_pc`) & ~`bp_mask`. On `bp_hit`, go to PAUSE; the instruction at `brk_pc` has not executed.
    - When the halt instruction retires, go to FLUSH.
  - PAUSE: `core_run`=0 except on a `stp` edge, which gives `core_run` = ~`stall` for exactly that cycle.
    - A step that retires a halt goes to FLUSH.
    - A `go` edge goes to RUN with `bp_mask` set. `bp_mask` clears after the first retired instruction, so a resume never re-hits the same breakpoint.
  - FLUSH: if the packer holds 1–7 bits, pad the high bits with 0, push the byte, then go to IDLE. If the packer is empty, go straight to IDLE.
- Abort: an `abt` edge in any state goes to IDLE next cycle. `core_run` is 0 in that cycle and any partial packer byte is discarded. Priority order: `abt` > watchdog > `bp_hit` > `stall`.
- Output packer:
  - Retired output bits shift in LSB-first. A 3-bit count wraps after 7.
  - The 8th bit loads the holding register and sets `out_vld`.
  - `stall` is raised if the 8th bit arrives while `out_vld` is high and `out_rdy` is low. A load in the same cycle as a handshake is allowed (full throughput).
- Input unpacker:
  - `in_rdy` = unpacker empty. An accepted byte supplies `core_ibit` = buffer[count], LSB first.
  - An input instruction with the unpacker empty raises `stall`.
- `stall` = (`core_out` & packer blocked) | (`core_in` & unpacker empty).

## Timing
- Reset values: `state`=IDLE; `core_run`, `core_start`, `out_vld`, `stall`, `wdog_trip` all 0; `out_byte`=0; `in_rdy`=1; counts 0; `bp_mask`=0.
- Button edges act in the same cycle the level rises. Holding a button produces one event.
- `core_run` is combinational from the FSM state and I/O status. It is never high in IDLE or FLUSH.
- A bit retired on cycle n becomes visible in `out_vld` at n+1 when it completes a byte.
- After `in_vld`&`in_rdy` on cycle n, `core_ibit` is valid at n+1.
- A host byte and a stalled input instruction unblock the core on the cycle after the byte is accepted.

## Configuration
- `BOOLFUCK_WDOG_EN` defined: a W-bit counter counts retired instructions since start.
  - When the counter reaches all-ones, the FSM goes to IDLE with no flush, and `wdog_trip` is set.
  - `wdog_trip` clears on the next `core_start`.
- `BOOLFUCK_WDOG_EN` undefined: no counter; `wdog_trip` is tied to 0.

## Structure
- `boolfuck_pkg` holds:
  - `ctrl_state_t` (2-bit: IDLE=0, RUN=1, PAUSE=2, FLUSH=3);
  - the 3-bit opcode constants shared with the core;
  - `BYTE_W`=8.
- Sub-module `boolfuck_pack`: the output shift register, count, holding register, pad/flush and handshake logic. The unpacker stays inline.

## Test plan
- Start with program `out,out` ×4 and `core_obit`=1,0,1,0,1,0,1,0 → one `out_vld` with `out_byte`=8'h55, then FLUSH, then IDLE.
- Halt retires after 3 output bits 1,1,1 → FLUSH emits 8'h07 → IDLE.
- `brk_pc`=5 with `brk_en` → PAUSE with `core_pc`=5 and no retire. A `stp` edge retires exactly one instruction. A `go` edge resumes without re-pausing at 5.
- Input instruction with an empty unpacker → `stall`=1, `core_run`=0. Host sends 8'h02 → next eight input bits are 0,1,0,0,0,0,0,0.
- Hold `out_rdy`=0 while a second byte completes → `stall`=1 until the handshake, and the second byte is not lost.
- With `BOOLFUCK_WDOG_EN` and W=4, run an infinite loop → IDLE after 15 retires with `wdog_trip`=1. An `abt` edge mid-RUN → IDLE next cycle.
